// File: rtl/mips_alu_dmem_if.sv
// Purpose : operand/result/memory bundle between the MIPS decode stage and the ALU + data memory.
// Latency : n/a (signal grouping only).
// Backpressure: none; the single-cycle datapath always accepts its inputs.
//
// Port summary:
//   opcode/shamt/funct  instruction fields decoded by the ALU
//   in1/in2             operands A (Rs) and B (Rt or sign-extended immediate)
//   result/zero/rw      ALU result, result==0 flag, register-file write enable
//   address/wdata       data memory byte address and store data
//   rdata               load data
interface mips_alu_dmem_if;
    logic [5:0]  opcode;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] result;
    logic        zero;
    logic        rw;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // Processor side: drives instruction fields, operands and memory request.
    modport master (
        output opcode, shamt, funct, in1, in2, address, wdata,
        input  result, zero, rw, rdata
    );

    // Execute/memory stage side.
    modport slave (
        input  opcode, shamt, funct, in1, in2, address, wdata,
        output result, zero, rw, rdata
    );
endinterface

// File: rtl/mips_alu_dmem.sv
// Purpose : execute + memory stage of the single-cycle MIPS core: integer ALU and word-addressed data memory.
// Latency : ALU and load data are combinational (0 cycles); stores land on the rising edge ending the SW cycle.
// Backpressure: none; one instruction is accepted every cycle.
//
// Port summary:
//   clk  processor clock, all state updates on the rising edge
//   rst  synchronous active-high reset; clears every memory word, drops a coincident store
//   bus  mips_alu_dmem_if.slave: opcode/shamt/funct/in1/in2 -> result/zero/rw,
//        address/wdata -> rdata
module mips_alu_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    mips_alu_dmem_if.slave bus
);

    // ------------------------------------------------------------------
    // Instruction encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    // ------------------------------------------------------------------
    // ALU: purely combinational, independent of rst
    // ------------------------------------------------------------------
    logic [31:0] alu_res;
    logic        alu_rw;
    logic [31:0] sum_dat;
    logic [31:0] diff_dat;

    // Shared adder/subtractor: LW/SW reuse the add path for address
    // generation, BEQ/BNE reuse the subtract path for comparison.
    assign sum_dat  = bus.in1 + bus.in2;
    assign diff_dat = bus.in1 - bus.in2;

    always_comb begin
        alu_res = 32'h0;
        alu_rw  = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD: begin
                        alu_res = sum_dat;
                        alu_rw  = 1'b1;
                    end
                    FN_SUB: begin
                        alu_res = diff_dat;
                        alu_rw  = 1'b1;
                    end
                    FN_AND: begin
                        alu_res = bus.in1 & bus.in2;
                        alu_rw  = 1'b1;
                    end
                    FN_OR: begin
                        alu_res = bus.in1 | bus.in2;
                        alu_rw  = 1'b1;
                    end
                    FN_SLL: begin
                        alu_res = bus.in2 << bus.shamt;
                        alu_rw  = 1'b1;
                    end
                    FN_SRL: begin
                        alu_res = bus.in2 >> bus.shamt;
                        alu_rw  = 1'b1;
                    end
                    // Unsupported funct behaves as a NOP: no result, no write-back.
                    default: begin
                        alu_res = 32'h0;
                        alu_rw  = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                alu_res = sum_dat;
                alu_rw  = 1'b1;
            end
            OP_SW: begin
                alu_res = sum_dat;
                alu_rw  = 1'b0;
            end
            // Branch target/decision is resolved outside from zero/result.
            OP_BEQ, OP_BNE: begin
                alu_res = diff_dat;
                alu_rw  = 1'b0;
            end
            default: begin
                alu_res = 32'h0;
                alu_rw  = 1'b0;
            end
        endcase
    end

    assign bus.result = alu_res;
    assign bus.rw     = alu_rw;
    assign bus.zero   = (alu_res == 32'h0);

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] word_idx;
    logic          store_vld;

    // Byte offset [1:0] and everything above the word index are dropped,
    // so unaligned addresses round down and addresses wrap modulo DEPTH*4.
    assign word_idx  = bus.address[AW+1:2];
    assign store_vld = (bus.opcode == OP_SW);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:AW+2], bus.address[1:0]};

    // Reset wins over a coincident store, so the SW in the reset cycle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (store_vld) begin
            mem_q[word_idx] <= bus.wdata;
        end
    end

    // Asynchronous read: a same-address store is visible only after its edge.
    assign bus.rdata = mem_q[word_idx];

endmodule

// File: tb/tb_mips_alu_dmem.sv
module tb_mips_alu_dmem;

    localparam int DEPTH = 64;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        rw;
    } alu_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_alu_dmem_if bus ();

    mips_alu_dmem #(.DEPTH(DEPTH), .AW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu_exp_t    alu_q [$];
    logic [31:0] rd_q  [$];
    int n_cmp = 0;
    int n_bad = 0;

    // Inputs change on the falling edge; outputs are sampled 2ns later.
    task automatic drive(input logic [5:0] op, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.opcode  = op;
        bus.shamt   = sh;
        bus.funct   = fn;
        bus.in1     = a;
        bus.in2     = b;
        bus.address = addr;
        bus.wdata   = wd;
    endtask

    task automatic test_reset;
        alu_exp_t e;
        logic [31:0] addrs [3];
        logic [31:0] got;
        addrs = '{32'd0, 32'd4, 32'd252};
        rst = 1'b1;
        drive(OP_R, 5'd0, FN_ADD, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        // ALU is independent of rst: SLL 3<<2 while reset held
        drive(OP_R, 5'd2, FN_SLL, 32'd0, 32'd3, 32'd0, 32'd0);
        alu_q.push_back('{res: 32'd12, z: 1'b0, rw: 1'b1});
        #2;
        e = alu_q.pop_front();
        n_cmp++;
        if ({bus.result, bus.zero, bus.rw} !== e) begin
            n_bad++;
            $display("FAIL alu_during_reset: got res=%h z=%b rw=%b want res=%h z=%b rw=%b",
                     bus.result, bus.zero, bus.rw, e.res, e.z, e.rw);
        end
        for (int i = 0; i < 3; i++) begin
            drive(OP_R, 5'd0, FN_ADD, 32'd0, 32'd0, addrs[i], 32'd0);
            rd_q.push_back(32'h0);
            #2;
            got = rd_q.pop_front();
            n_cmp++;
            if (bus.rdata !== got) begin
                n_bad++;
                $display("FAIL reset_rdata[%0d]: got %h want %h", addrs[i], bus.rdata, got);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_rtype;
        logic [5:0]  fn [5];
        logic [31:0] a  [5];
        logic [31:0] b  [5];
        alu_exp_t    ex [5];
        alu_exp_t    e;
        fn = '{FN_ADD, FN_SUB, FN_AND, FN_OR, 6'b100111};
        a  = '{32'd7, 32'd5, 32'h0000F0F0, 32'h0000F0F0, 32'h1234};
        b  = '{32'd5, 32'd7, 32'h00000FF0, 32'h00000FF0, 32'h5678};
        ex = '{'{32'd12, 1'b0, 1'b1}, '{32'hFFFFFFFE, 1'b0, 1'b1},
               '{32'h000000F0, 1'b0, 1'b1}, '{32'h0000FFF0, 1'b0, 1'b1},
               '{32'h0, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            drive(OP_R, 5'd0, fn[i], a[i], b[i], 32'd0, 32'd0);
            alu_q.push_back(ex[i]);
            #2;
            e = alu_q.pop_front();
            n_cmp++;
            if ({bus.result, bus.zero, bus.rw} !== e) begin
                n_bad++;
                $display("FAIL rtype[%0d] funct=%b: got res=%h z=%b rw=%b want res=%h z=%b rw=%b",
                         i, fn[i], bus.result, bus.zero, bus.rw, e.res, e.z, e.rw);
            end
        end
    endtask

    task automatic test_shifts;
        logic [5:0]  fn [4];
        logic [4:0]  sh [4];
        logic [31:0] b  [4];
        logic [31:0] r  [4];
        alu_exp_t    e;
        fn = '{FN_SLL, FN_SRL, FN_SLL, FN_SRL};
        sh = '{5'd31, 5'd31, 5'd0, 5'd0};
        b  = '{32'h1, 32'h80000000, 32'hA5A5_0F0F, 32'h8000_0001};
        r  = '{32'h80000000, 32'h1, 32'hA5A5_0F0F, 32'h8000_0001};
        for (int i = 0; i < 4; i++) begin
            // in1 is non-zero to show shifts use in2 only
            drive(OP_R, sh[i], fn[i], 32'hFFFF_FFFF, b[i], 32'd0, 32'd0);
            alu_q.push_back('{res: r[i], z: 1'b0, rw: 1'b1});
            #2;
            e = alu_q.pop_front();
            n_cmp++;
            if ({bus.result, bus.zero, bus.rw} !== e) begin
                n_bad++;
                $display("FAIL shift[%0d]: got res=%h z=%b rw=%b want res=%h z=%b rw=%b",
                         i, bus.result, bus.zero, bus.rw, e.res, e.z, e.rw);
            end
        end
    endtask

    task automatic test_branch_mem_ops;
        logic [5:0]  op [5];
        logic [31:0] a  [5];
        logic [31:0] b  [5];
        alu_exp_t    ex [5];
        alu_exp_t    e;
        op = '{OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_BAD};
        a  = '{32'd9, 32'd9, 32'd100, 32'd100, 32'd9};
        b  = '{32'd9, 32'd4, 32'd8, 32'd8, 32'd4};
        ex = '{'{32'd0, 1'b1, 1'b0}, '{32'd5, 1'b0, 1'b0}, '{32'd108, 1'b0, 1'b1},
               '{32'd108, 1'b0, 1'b0}, '{32'd0, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            // funct is ADD to show it is ignored outside R-type
            drive(op[i], 5'd0, FN_ADD, a[i], b[i], 32'd400, 32'd0);
            alu_q.push_back(ex[i]);
            #2;
            e = alu_q.pop_front();
            n_cmp++;
            if ({bus.result, bus.zero, bus.rw} !== e) begin
                n_bad++;
                $display("FAIL opcode[%0d]=%b: got res=%h z=%b rw=%b want res=%h z=%b rw=%b",
                         i, op[i], bus.result, bus.zero, bus.rw, e.res, e.z, e.rw);
            end
        end
    endtask

    task automatic test_store_load;
        logic [31:0] addrs [3];
        logic [31:0] got;
        addrs = '{32'd8, 32'd9, 32'd264};
        drive(OP_SW, 5'd0, FN_ADD, 32'd8, 32'd0, 32'd8, 32'hDEADBEEF);
        rd_q.push_back(32'h0); // old word until the edge
        #2;
        got = rd_q.pop_front();
        n_cmp++;
        if (bus.rdata !== got) begin
            n_bad++;
            $display("FAIL sw_same_cycle_old: got %h want %h", bus.rdata, got);
        end
        for (int i = 0; i < 3; i++) begin
            drive(OP_LW, 5'd0, FN_ADD, addrs[i], 32'd0, addrs[i], 32'h0);
            rd_q.push_back(32'hDEADBEEF);
            #2;
            got = rd_q.pop_front();
            n_cmp++;
            if (bus.rdata !== got) begin
                n_bad++;
                $display("FAIL load_addr[%0d]: got %h want %h", addrs[i], bus.rdata, got);
            end
        end
    endtask

    task automatic test_write_gating;
        logic [5:0] op [4];
        logic [5:0] fn [4];
        logic [31:0] got;
        op = '{OP_LW, OP_R, OP_BEQ, OP_LW};
        fn = '{FN_ADD, FN_ADD, FN_ADD, FN_ADD};
        // Each non-SW cycle carries wdata 1234; the read in the following cycle must still be 0.
        for (int i = 0; i < 4; i++) begin
            drive(op[i], 5'd0, fn[i], 32'd12, 32'd0, 32'd12, 32'd1234);
            rd_q.push_back(32'h0);
            #2;
            got = rd_q.pop_front();
            n_cmp++;
            if (bus.rdata !== got) begin
                n_bad++;
                $display("FAIL gating[%0d] op=%b: got %h want %h", i, op[i], bus.rdata, got);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            drive(OP_SW, 5'd0, FN_ADD, 32'(i * 4), 32'd0, 32'(i * 4), 32'h1000_0000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            drive(OP_LW, 5'd0, FN_ADD, 32'(i * 4), 32'd0, 32'(i * 4), 32'h0);
            rd_q.push_back(32'h1000_0000 + 32'(i));
            #2;
            got = rd_q.pop_front();
            n_cmp++;
            if (bus.rdata !== got) begin
                n_bad++;
                $display("FAIL b2b_word[%0d]: got %h want %h", i, bus.rdata, got);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] addrs [6];
        logic [31:0] got;
        addrs = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd264, 32'd8};
        // SW to word 2 coincident with reset; old content still visible before the edge
        drive(OP_SW, 5'd0, FN_ADD, 32'd8, 32'd0, 32'd8, 32'h5555_5555);
        rst = 1'b1;
        rd_q.push_back(32'h1000_0002);
        #2;
        got = rd_q.pop_front();
        n_cmp++;
        if (bus.rdata !== got) begin
            n_bad++;
            $display("FAIL reset_cycle_old: got %h want %h", bus.rdata, got);
        end
        for (int i = 0; i < 6; i++) begin
            drive(OP_LW, 5'd0, FN_ADD, addrs[i], 32'd0, addrs[i], 32'h0);
            rst = 1'b0;
            rd_q.push_back(32'h0);
            #2;
            got = rd_q.pop_front();
            n_cmp++;
            if (bus.rdata !== got) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: got %h want %h", addrs[i], bus.rdata, got);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        bus.opcode  = 6'd0;
        bus.shamt   = 5'd0;
        bus.funct   = 6'd0;
        bus.in1     = 32'd0;
        bus.in2     = 32'd0;
        bus.address = 32'd0;
        bus.wdata   = 32'd0;
        test_reset();
        test_rtype();
        test_shifts();
        test_branch_mem_ops();
        test_store_load();
        test_write_gating();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
